matrix_frame_sequencer: RTL and testbench

Scan and pattern sequencer for the 8x8 LED matrix row/column driver. It produces the row index and row-enable (with anti-ghosting blanking) that the driver's row decode consumes. It also selects which of the four stored patterns is shown. Pattern changes happen only at frame boundaries: by automatic dwell timing, by single-step while paused, or by a host jump request over a valid/ready handshake.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_row_timer.sv | 80 ++++++++
 rtl/matrix_frame_sequencer.sv | 111 +++++++++++
 tb/tb_matrix_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the 8x8 LED matrix scan sequencer and row/column
// driver: matrix geometry, pattern-index width, the row-slot FSM state type
// and a wrapping pattern-increment helper.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;
  localparam int PAT_W    = 2;
  localparam int NUM_PAT  = 4;

  // Row-slot phase: leading blanking cycles, then the driven part of the slot.
  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_t;

  // Next pattern index, wrapping from the last stored pattern back to 0.
  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
    return (p == PAT_W'(NUM_PAT - 1)) ? '0 : p + PAT_W'(1);
  endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// -----------------------------------------------------------------------------
// matrix_row_timer
// Free-running row scan timer. Divides row_clk into row slots of ROW_DIV
// cycles, steps row_idx through 0..7, blanks the first BLANK_CYC cycles of
// every slot and flags the last cycle of each frame.
//
// Ports:
//   row_clk   in   scan clock, rising edge
//   reset     in   asynchronous, active-low reset
//   row_idx   out  [2:0] current row (registered)
//   row_en    out  row drive enable, low while blanking (registered)
//   frame_end out  high during the last cycle of row 7; the following edge
//                  is the frame boundary
// -----------------------------------------------------------------------------
module matrix_row_timer
  import matrix_pkg::*;
#(
  parameter int ROW_DIV   = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic             row_clk,
  input  logic             reset,
  output logic [ROW_W-1:0] row_idx,
  output logic             row_en,
  output logic             frame_end
);

  localparam int DIV_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [ROW_W-1:0] row_next;
  logic             slot_end;
  scan_state_t      state_q;
  scan_state_t      state_d;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    slot_end  = 1'b0;
    div_next  = div_cnt + DIV_W'(1);
    row_next  = row_idx;
    state_d   = ST_ACTIVE;
    frame_end = 1'b0;

    if (div_cnt == DIV_W'(ROW_DIV - 1)) begin
      slot_end = 1'b1;
      div_next = '0;
      row_next = (row_idx == ROW_W'(NUM_ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
      frame_end = (row_idx == ROW_W'(NUM_ROWS - 1));
    end

    // The state is computed from the next count so the registered enable
    // lines up with the slot phase it describes.
    if (int'(div_next) < BLANK_CYC) begin
      state_d = ST_BLANK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge row_clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      row_idx <= '0;
      state_q <= ST_BLANK;
    end else begin
      div_cnt <= div_next;
      row_idx <= row_next;
      state_q <= state_d;
    end
  end

  assign row_en = (state_q == ST_ACTIVE);

  // slot_end is only needed to build frame_end; keep it visible for debug.
  logic unused_slot_end;
  assign unused_slot_end = slot_end;

endmodule

// File: rtl/matrix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_frame_sequencer
// Scan and pattern sequencer for the 8x8 LED matrix driver. Runs the row scan
// continuously and selects one of four stored patterns. The pattern changes
// only at frame boundaries: after FRAMES_PER_PAT frames in run mode, by a
// single step while paused, or by a host jump request (valid/ready).
//
// Ports:
//   row_clk     in   scan clock, rising edge
//   reset       in   asynchronous, active-low reset
//   run         in   1 = auto-advance patterns, 0 = hold pattern
//   step        in   one-cycle pulse; advance one pattern while run=0
//   sel_valid   in   host jump request valid
//   sel_pat     in   [1:0] requested pattern, captured on handshake
//   sel_ready   out  request can be accepted (no jump pending)
//   row_idx     out  [2:0] current row
//   row_en      out  row drive enable, low during blanking
//   frame_start out  one-cycle pulse on the first cycle of row 0
//   pattern     out  [1:0] pattern index for the driver's data select
// -----------------------------------------------------------------------------
module matrix_frame_sequencer
  import matrix_pkg::*;
#(
  parameter int ROW_DIV        = 4,
  parameter int BLANK_CYC      = 1,
  parameter int FRAMES_PER_PAT = 4
) (
  input  logic             row_clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             sel_valid,
  input  logic [PAT_W-1:0] sel_pat,
  output logic             sel_ready,
  output logic [ROW_W-1:0] row_idx,
  output logic             row_en,
  output logic             frame_start,
  output logic [PAT_W-1:0] pattern
);

  localparam int FCNT_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PAT - 1);

  logic              frame_end;
  logic [FCNT_W-1:0] frame_cnt;
  logic              sel_pend;
  logic [PAT_W-1:0]  sel_reg;
  logic              step_pend;
  logic              sel_applied;
  logic              handshake;

  matrix_row_timer #(
    .ROW_DIV   (ROW_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_row_timer (
    .row_clk   (row_clk),
    .reset     (reset),
    .row_idx   (row_idx),
    .row_en    (row_en),
    .frame_end (frame_end)
  );

  assign sel_ready = ~sel_pend;
  assign handshake = sel_valid & sel_ready;

  always_ff @(posedge row_clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      pattern     <= '0;
      frame_cnt   <= '0;
      sel_pend    <= 1'b0;
      sel_reg     <= '0;
      step_pend   <= 1'b0;
      sel_applied <= 1'b0;
    end else begin
      frame_start <= frame_end;
      // A consumed jump keeps sel_ready low for one more cycle after the
      // boundary, so the host sees ready return after the new pattern.
      sel_applied <= frame_end & sel_pend;

      if (frame_end) begin
        if (sel_pend) begin
          pattern   <= sel_reg;
          frame_cnt <= '0;
        end else if (step_pend) begin
          pattern <= pat_next(pattern);
        end else if (run) begin
          if (frame_cnt == FCNT_LAST) begin
            pattern   <= pat_next(pattern);
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
          end
        end
      end

      if (handshake) begin
        sel_pend <= 1'b1;
        sel_reg  <= sel_pat;
      end else if (sel_applied) begin
        sel_pend <= 1'b0;
      end

      // Every boundary consumes or discards the pending step; a step seen on
      // the boundary edge itself is kept for the next boundary. Steps while
      // running are ignored.
      step_pend <= (step & ~run) | (step_pend & ~frame_end);
    end
  end

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_frame_sequencer
// Directed and randomized stimulus for matrix_frame_sequencer, compared every
// cycle against a cycle-count reference model of the scan and pattern rules.
// -----------------------------------------------------------------------------
module tb_matrix_frame_sequencer;

  localparam int ROW_DIV   = 4;
  localparam int BLANK_CYC = 1;
  localparam int FPP       = 4;
  localparam int FRAME     = 8 * ROW_DIV;

  logic       row_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       run     = 1'b0;
  logic       step    = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_pat = 2'd0;
  logic       sel_ready;
  logic [2:0] row_idx;
  logic       row_en;
  logic       frame_start;
  logic [1:0] pattern;

  always #5 row_clk = ~row_clk;

  matrix_frame_sequencer #(
    .ROW_DIV        (ROW_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .FRAMES_PER_PAT (FPP)
  ) dut (
    .row_clk     (row_clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .sel_valid   (sel_valid),
    .sel_pat     (sel_pat),
    .sel_ready   (sel_ready),
    .row_idx     (row_idx),
    .row_en      (row_en),
    .frame_start (frame_start),
    .pattern     (pattern)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: cycle count since reset release plus pattern bookkeeping.
  int t;
  int m_pat;
  int m_fcnt;
  int m_sel_reg;
  int m_release_at;
  bit m_sel_pend;
  bit m_step_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d: observed %0d required %0d", tag, t, obs, exp);
  endtask

  task automatic model_reset();
    t            = 0;
    m_pat        = 0;
    m_fcnt       = 0;
    m_sel_reg    = 0;
    m_release_at = -1;
    m_sel_pend   = 1'b0;
    m_step_pend  = 1'b0;
  endtask

  task automatic check_outputs();
    check("row_idx",     {29'd0, row_idx},     (t / ROW_DIV) % 8);
    check("row_en",      {31'd0, row_en},      32'((t % ROW_DIV) >= BLANK_CYC));
    check("frame_start", {31'd0, frame_start}, 32'(t > 0 && (t % FRAME) == 0));
    check("pattern",     {30'd0, pattern},     m_pat);
    check("sel_ready",   {31'd0, sel_ready},   32'(!m_sel_pend));
  endtask

  // Advance the model across one rising edge using the inputs now driven,
  // then compare all outputs 1 ns after the edge.
  task automatic tick();
    bit hs;
    bit bnd;
    hs = sel_valid && !m_sel_pend;
    t++;
    bnd = ((t % FRAME) == 0);
    if (bnd) begin
      if (m_sel_pend) begin
        m_pat        = m_sel_reg;
        m_fcnt       = 0;
        m_step_pend  = 1'b0;
        m_release_at = t + 1;
      end else if (m_step_pend) begin
        m_pat       = (m_pat + 1) % 4;
        m_step_pend = 1'b0;
      end else if (run) begin
        if (m_fcnt == FPP - 1) begin
          m_pat  = (m_pat + 1) % 4;
          m_fcnt = 0;
        end else begin
          m_fcnt++;
        end
      end
    end
    if (t == m_release_at) m_sel_pend = 1'b0;
    if (hs) begin
      m_sel_pend = 1'b1;
      m_sel_reg  = int'(sel_pat);
    end
    if (step && !run) m_step_pend = 1'b1;
    @(posedge row_clk);
    #1;
    check_outputs();
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Assert reset away from a clock edge, check outputs at once, hold it over
  // two edges and release on a falling edge (cycle 0 of the new run).
  task automatic apply_reset();
    reset     = 1'b0;
    run       = 1'b0;
    step      = 1'b0;
    sel_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge row_clk);
    @(negedge row_clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge row_clk);
    #2;

    // Free run: frame_start every frame, dwell of four frames, wrap 3->0.
    apply_reset();
    run = 1'b1;
    run_to(31);
    check("no_first_frame_pulse", {31'd0, frame_start}, 0);
    run_to(32);
    check("first_frame_start", {31'd0, frame_start}, 1);
    run_to(127);
    check("pat_before_128", {30'd0, pattern}, 0);
    run_to(128);
    check("pat_at_128", {30'd0, pattern}, 1);
    run_to(511);
    check("pat_before_512", {30'd0, pattern}, 3);
    run_to(512);
    check("pat_wrap_512", {30'd0, pattern}, 0);
    run_to(520);

    // Paused: two steps in one frame collapse to one advance.
    apply_reset();
    run_to(40);
    pulse_step();
    run_to(45);
    pulse_step();
    run_to(63);
    check("step_pat_63", {30'd0, pattern}, 0);
    run_to(64);
    check("step_pat_64", {30'd0, pattern}, 1);
    run_to(320);
    check("paused_hold", {30'd0, pattern}, 1);
    run = 1'b1;
    run_to(330);
    pulse_step();
    run_to(360);
    pulse_step();
    run_to(400);
    pulse_step();
    run_to(447);
    check("run_step_dropped", {30'd0, pattern}, 1);
    run_to(448);
    check("run_advance_448", {30'd0, pattern}, 2);

    // Jump request to pattern 2.
    apply_reset();
    run = 1'b1;
    run_to(10);
    sel_valid = 1'b1;
    sel_pat   = 2'd2;
    tick();
    sel_valid = 1'b0;
    check("ready_low_11", {31'd0, sel_ready}, 0);
    run_to(32);
    check("jump_pat_32", {30'd0, pattern}, 2);
    check("ready_low_32", {31'd0, sel_ready}, 0);
    run_to(33);
    check("ready_high_33", {31'd0, sel_ready}, 1);
    run_to(159);
    check("jump_dwell_159", {30'd0, pattern}, 2);
    run_to(160);
    check("jump_advance_160", {30'd0, pattern}, 3);

    // Second request held while not ready is accepted only at cycle 33.
    apply_reset();
    run = 1'b1;
    run_to(10);
    sel_valid = 1'b1;
    sel_pat   = 2'd2;
    tick();
    sel_pat = 2'd1;
    while (sel_ready !== 1'b1 && t < 100) tick();
    check("second_accept_cycle", t, 33);
    tick();
    sel_valid = 1'b0;
    check("second_ready_low", {31'd0, sel_ready}, 0);
    run_to(64);
    check("second_jump_pat_64", {30'd0, pattern}, 1);

    // Jump to 0 collides with the auto advance due at cycle 128.
    apply_reset();
    run = 1'b1;
    run_to(100);
    sel_valid = 1'b1;
    sel_pat   = 2'd0;
    tick();
    sel_valid = 1'b0;
    run_to(128);
    check("collision_pat_128", {30'd0, pattern}, 0);
    run_to(255);
    check("collision_pat_255", {30'd0, pattern}, 0);
    run_to(256);
    check("collision_pat_256", {30'd0, pattern}, 1);

    // Reset mid-row with a jump pending: the request is lost.
    apply_reset();
    run = 1'b1;
    run_to(40);
    sel_valid = 1'b1;
    sel_pat   = 2'd3;
    tick();
    sel_valid = 1'b0;
    run_to(50);
    apply_reset();
    run = 1'b1;
    run_to(32);
    check("reset_req_lost", {30'd0, pattern}, 0);
    run_to(40);

    // Randomized traffic on all control inputs.
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) run = ~run;
      step      = ($urandom_range(0, 15) == 0);
      sel_valid = ($urandom_range(0, 7) == 0);
      sel_pat   = 2'($urandom);
      tick();
    end
    step      = 1'b0;
    sel_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
